// File: rtl/gba_bw_pkg.sv
// Shared types and constants for the GBA 1-bpp bitmap pixel fetcher.
// Holds the fetch FSM state enum and bitmap RAM geometry.
package gba_bw_pkg;

    localparam int BANK_DEPTH = 64;
    localparam int ADDR_W     = 6;
    localparam int BYTE_W     = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_STREAM = 2'd2,
        S_FLUSH  = 2'd3
    } state_e;

endpackage

// File: rtl/gba_bw_byte_serializer.sv
// Byte holding register plus 8-bit MSB-first shift register.
// Bytes enter with ready/valid; pixels leave with ready/valid.
module gba_bw_byte_serializer
    import gba_bw_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_bit,
    output logic              out_last,
    output logic              loaded
);

    logic [BYTE_W-1:0] hold_q;
    logic [BYTE_W-1:0] shift_q;
    logic              hold_full_q;
    logic              hold_last_q;
    logic              shift_last_q;
    logic [3:0]        cnt_q;

    logic out_fire;
    logic in_fire;
    logic shift_free;

    assign out_valid  = (cnt_q != 4'd0);
    assign out_fire   = out_valid && out_ready;
    assign shift_free = (cnt_q == 4'd0) || ((cnt_q == 4'd1) && out_fire);
    assign in_ready   = !hold_full_q;
    assign in_fire    = in_valid && in_ready;
    assign out_bit    = shift_q[BYTE_W-1];
    assign out_last   = shift_last_q && (cnt_q == 4'd1);
    assign loaded     = shift_free && (hold_full_q || in_fire);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q       <= '0;
            shift_q      <= '0;
            hold_full_q  <= 1'b0;
            hold_last_q  <= 1'b0;
            shift_last_q <= 1'b0;
            cnt_q        <= 4'd0;
        end else begin
            if (shift_free) begin
                if (hold_full_q) begin
                    shift_q      <= hold_q;
                    shift_last_q <= hold_last_q;
                    cnt_q        <= 4'd8;
                end else if (in_fire) begin
                    // Empty pipeline: bypass the holding register
                    shift_q      <= in_data;
                    shift_last_q <= in_last;
                    cnt_q        <= 4'd8;
                end else if (out_fire) begin
                    cnt_q        <= cnt_q - 4'd1;
                    shift_last_q <= 1'b0;
                end
            end else if (out_fire) begin
                shift_q <= {shift_q[BYTE_W-2:0], 1'b0};
                cnt_q   <= cnt_q - 4'd1;
            end

            if (in_fire && !shift_free) begin
                hold_q      <= in_data;
                hold_last_q <= in_last;
                hold_full_q <= 1'b1;
            end else if (hold_full_q && shift_free) begin
                hold_full_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/gba_bw_pixel_fetch.sv
// Streams a banked 1-bpp bitmap out as a pixel ready/valid stream.
// Define GBA_BW_FETCH_INVERT_EN to output inverted pixels (1 = black).
module gba_bw_pixel_fetch
    import gba_bw_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int BANK_W    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [BANK_W-1:0] mem_bank,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [BYTE_W-1:0] mem_data,
    input  logic              mem_valid,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_data,
    output logic              pix_last
);

    localparam int IDX_W = BANK_W + ADDR_W;
    localparam logic [IDX_W-1:0] LAST_IDX =
        IDX_W'(NUM_BANKS * BANK_DEPTH - 1);

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic             rd_pend_q;
    logic             rd_done_q;
    logic             done_q;

    logic ser_in_valid;
    logic ser_in_ready;
    logic ser_bit;
    logic ser_last;
    logic ser_loaded;
    logic rd_go;
    logic last_acc;

    assign rd_go = ((state_q == S_FILL) || (state_q == S_STREAM))
                && ser_in_ready && !rd_pend_q && !rd_done_q;

    assign mem_rd_en    = rd_go;
    assign mem_bank     = idx_q[IDX_W-1:ADDR_W];
    assign mem_rd_addr  = idx_q[ADDR_W-1:0];
    assign ser_in_valid = mem_valid && rd_pend_q;
    assign last_acc     = pix_valid && pix_ready && ser_last;
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign pix_last     = ser_last;

`ifdef GBA_BW_FETCH_INVERT_EN
    assign pix_data = pix_valid & ~ser_bit;
`else
    assign pix_data = pix_valid & ser_bit;
`endif

    gba_bw_byte_serializer u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (ser_in_valid),
        .in_data   (mem_data),
        .in_last   (rd_done_q),
        .in_ready  (ser_in_ready),
        .out_valid (pix_valid),
        .out_ready (pix_ready),
        .out_bit   (ser_bit),
        .out_last  (ser_last),
        .loaded    (ser_loaded)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            rd_pend_q <= 1'b0;
            rd_done_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (rd_go) begin
                rd_pend_q <= 1'b1;
                idx_q     <= idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX)
                    rd_done_q <= 1'b1;
            end else if (mem_valid) begin
                rd_pend_q <= 1'b0;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_FILL;
                        idx_q     <= '0;
                        rd_done_q <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (ser_loaded)
                        state_q <= S_STREAM;
                end
                S_STREAM: begin
                    if (last_acc) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end else if (rd_done_q) begin
                        state_q <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (last_acc) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
